// File: rtl/mel_reshape_pkg.sv
// Shared types and sizing helpers for the mel frame serializer.
// Beat count and last-beat lane count are derived with ceil_div.
package mel_reshape_pkg;

    localparam int DATA_W_DEF = 16;

    typedef logic [DATA_W_DEF-1:0] sample_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/mel_beat_mux.sv
// Selects one beat of a stored frame, inserting pad values and the keep mask.
// Purely combinational; lane j of beat b maps to coefficient b*OUT_WIDTH+j.
module mel_beat_mux
    import mel_reshape_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int N_IN      = 40,
    parameter int OUT_WIDTH = 20,
    parameter int PAD_VALUE = 0,
    parameter int BEATS     = ceil_div(N_IN, OUT_WIDTH),
    parameter int BW        = $clog2(BEATS + 1)
) (
    input  logic [N_IN-1:0][DATA_W-1:0]      slot,
    input  logic [BW-1:0]                    beat,
    output logic [OUT_WIDTH-1:0][DATA_W-1:0] lanes,
    output logic [OUT_WIDTH-1:0]             keep
);

    localparam int LAST_LANES = N_IN - (BEATS - 1) * OUT_WIDTH;

    logic [BEATS-1:0][OUT_WIDTH-1:0][DATA_W-1:0] cand;
    logic [BEATS-1:0][OUT_WIDTH-1:0]             kmask;

    // Only the final beat can carry lanes past the end of the frame.
    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        for (genvar j = 0; j < OUT_WIDTH; j++) begin : g_lane
            if ((b < BEATS - 1) || (j < LAST_LANES)) begin : g_real
                assign cand[b][j]  = slot[b*OUT_WIDTH+j];
                assign kmask[b][j] = 1'b1;
            end else begin : g_pad
                assign cand[b][j]  = DATA_W'(PAD_VALUE);
                assign kmask[b][j] = 1'b0;
            end
        end
    end

    always_comb begin
        lanes = {OUT_WIDTH{DATA_W'(PAD_VALUE)}};
        keep  = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat == BW'(b)) begin
                lanes = cand[b];
                keep  = kmask[b];
            end
        end
    end

endmodule

// File: rtl/mel_frame_serializer.sv
// Two-slot frame buffer that streams each mel frame as OUT_WIDTH-lane beats.
// A new frame can land in the free slot while the other one drains.
module mel_frame_serializer
    import mel_reshape_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int N_IN      = 40,
    parameter int OUT_WIDTH = 20,
    parameter int PAD_VALUE = 0,
    localparam int BEATS    = ceil_div(N_IN, OUT_WIDTH),
    localparam int BW       = $clog2(BEATS + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_IN-1:0][DATA_W-1:0]      in,
    input  logic                             s_valid,
    output logic                             s_ready,
    output logic [OUT_WIDTH-1:0][DATA_W-1:0] out,
    output logic [OUT_WIDTH-1:0]             m_keep,
    output logic [BW-1:0]                    m_beat,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic                             m_last
);

    logic [N_IN-1:0][DATA_W-1:0] slot_q [2];
    logic [N_IN-1:0][DATA_W-1:0] slot_d [2];
    logic                        wr_q, wr_d;
    logic                        rd_q, rd_d;
    logic [1:0]                  cnt_q, cnt_d;
    logic [BW-1:0]               beat_q, beat_d;

    logic accept;
    logic pop;
    logic last;

    // s_ready depends only on registered occupancy and reset.
    assign s_ready = (cnt_q < 2'd2) && !reset;
    assign m_valid = (cnt_q != 2'd0);
    assign last    = (beat_q == BW'(BEATS - 1));
    assign accept  = s_valid && s_ready;
    assign pop     = m_valid && m_ready;
    assign m_beat  = beat_q;
    assign m_last  = last;

    always_comb begin
        slot_d = slot_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        beat_d = beat_q;
        if (accept) begin
            slot_d[wr_q] = in;
            wr_d         = ~wr_q;
        end
        if (pop) begin
            if (last) begin
                beat_d = '0;
                rd_d   = ~rd_q;
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end
        case ({accept, pop && last})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            cnt_q  <= 2'd0;
            beat_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            beat_q <= beat_d;
        end
    end

    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    mel_beat_mux #(
        .DATA_W    (DATA_W),
        .N_IN      (N_IN),
        .OUT_WIDTH (OUT_WIDTH),
        .PAD_VALUE (PAD_VALUE),
        .BEATS     (BEATS),
        .BW        (BW)
    ) u_mux (
        .slot  (slot_q[rd_q]),
        .beat  (beat_q),
        .lanes (out),
        .keep  (m_keep)
    );

endmodule

// File: tb/tb_mel_frame_serializer.sv
// Directed bench for mel_frame_serializer in three lane configurations.
// Expected beats are rebuilt from the frame base value and lane arithmetic.
module tb_mel_frame_serializer;

    localparam int PAD_B = 48879;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [39:0][15:0] in_a, in_b, in_c;
    logic sv_a, sr_a, mv_a, mr_a, ml_a;
    logic sv_b, sr_b, mv_b, mr_b, ml_b;
    logic sv_c, sr_c, mv_c, mr_c, ml_c;
    logic [19:0][15:0] out_a;
    logic [15:0][15:0] out_b;
    logic [39:0][15:0] out_c;
    logic [19:0] keep_a;
    logic [15:0] keep_b;
    logic [39:0] keep_c;
    logic [1:0] beat_a, beat_b;
    logic [0:0] beat_c;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mel_frame_serializer #(.DATA_W(16), .N_IN(40), .OUT_WIDTH(20), .PAD_VALUE(0)) dut_a (
        .clk(clk), .reset(reset), .in(in_a), .s_valid(sv_a), .s_ready(sr_a),
        .out(out_a), .m_keep(keep_a), .m_beat(beat_a), .m_valid(mv_a),
        .m_ready(mr_a), .m_last(ml_a));

    mel_frame_serializer #(.DATA_W(16), .N_IN(40), .OUT_WIDTH(16), .PAD_VALUE(PAD_B)) dut_b (
        .clk(clk), .reset(reset), .in(in_b), .s_valid(sv_b), .s_ready(sr_b),
        .out(out_b), .m_keep(keep_b), .m_beat(beat_b), .m_valid(mv_b),
        .m_ready(mr_b), .m_last(ml_b));

    mel_frame_serializer #(.DATA_W(16), .N_IN(40), .OUT_WIDTH(40), .PAD_VALUE(0)) dut_c (
        .clk(clk), .reset(reset), .in(in_c), .s_valid(sv_c), .s_ready(sr_c),
        .out(out_c), .m_keep(keep_c), .m_beat(beat_c), .m_valid(mv_c),
        .m_ready(mr_c), .m_last(ml_c));

    function automatic logic [639:0] mk_frame(input int base);
        logic [639:0] f;
        f = '0;
        for (int i = 0; i < 40; i++) f[i*16 +: 16] = 16'(base + i);
        return f;
    endfunction

    function automatic logic [639:0] exp_beat(input int base, input int b,
                                              input int ow, input int pad);
        logic [639:0] e;
        int k;
        e = '0;
        for (int j = 0; j < ow; j++) begin
            k = b * ow + j;
            e[j*16 +: 16] = (k < 40) ? 16'(base + k) : 16'(pad);
        end
        return e;
    endfunction

    function automatic logic [39:0] exp_keep(input int b, input int ow);
        logic [39:0] m;
        m = '0;
        for (int j = 0; j < ow; j++) if (b * ow + j < 40) m[j] = 1'b1;
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sv_a = 0; sv_b = 0; sv_c = 0;
        mr_a = 1; mr_b = 1; mr_c = 1;
        in_a = '0; in_b = '0; in_c = '0;
        step();
        step();
        n_checks++;
        if (sr_a !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready got %b want 0", sr_a); end
        n_checks++;
        if (mv_a !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid got %b want 0", mv_a); end
        n_checks++;
        if (beat_a !== 2'd0) begin n_fail++; $display("FAIL rst_m_beat got %0d want 0", beat_a); end
        n_checks++;
        if (ml_a !== 1'b0) begin n_fail++; $display("FAIL rst_m_last_a got %b want 0", ml_a); end
        n_checks++;
        if (ml_c !== 1'b1) begin n_fail++; $display("FAIL rst_m_last_c got %b want 1", ml_c); end
        n_checks++;
        if (mv_c !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid_c got %b want 0", mv_c); end
        reset = 1'b0;
        #1;
        n_checks++;
        if (sr_a !== 1'b1) begin n_fail++; $display("FAIL post_rst_s_ready got %b want 1", sr_a); end
        n_checks++;
        if (sr_c !== 1'b1) begin n_fail++; $display("FAIL post_rst_s_ready_c got %b want 1", sr_c); end
    endtask

    task automatic test_default();
        logic [639:0] e;
        logic [39:0] k;
        in_a = mk_frame(0);
        sv_a = 1;
        step();
        sv_a = 0;
        for (int b = 0; b < 2; b++) begin
            e = exp_beat(0, b, 20, 0);
            k = exp_keep(b, 20);
            n_checks++;
            if (mv_a !== 1'b1) begin n_fail++; $display("FAIL def_valid b%0d got %b want 1", b, mv_a); end
            n_checks++;
            if (out_a !== e[319:0]) begin n_fail++; $display("FAIL def_out b%0d got %h want %h", b, out_a, e[319:0]); end
            n_checks++;
            if (keep_a !== k[19:0]) begin n_fail++; $display("FAIL def_keep b%0d got %h want %h", b, keep_a, k[19:0]); end
            n_checks++;
            if (beat_a !== 2'(b)) begin n_fail++; $display("FAIL def_beat got %0d want %0d", beat_a, b); end
            n_checks++;
            if (ml_a !== (b == 1)) begin n_fail++; $display("FAIL def_last b%0d got %b want %b", b, ml_a, b == 1); end
            step();
        end
        n_checks++;
        if (mv_a !== 1'b0) begin n_fail++; $display("FAIL def_idle got %b want 0", mv_a); end
    endtask

    task automatic test_partial();
        logic [639:0] e;
        logic [39:0] k;
        in_b = mk_frame(100);
        sv_b = 1;
        step();
        sv_b = 0;
        for (int b = 0; b < 3; b++) begin
            e = exp_beat(100, b, 16, PAD_B);
            k = exp_keep(b, 16);
            n_checks++;
            if (mv_b !== 1'b1) begin n_fail++; $display("FAIL part_valid b%0d got %b want 1", b, mv_b); end
            n_checks++;
            if (out_b !== e[255:0]) begin n_fail++; $display("FAIL part_out b%0d got %h want %h", b, out_b, e[255:0]); end
            n_checks++;
            if (keep_b !== k[15:0]) begin n_fail++; $display("FAIL part_keep b%0d got %h want %h", b, keep_b, k[15:0]); end
            n_checks++;
            if (beat_b !== 2'(b)) begin n_fail++; $display("FAIL part_beat got %0d want %0d", beat_b, b); end
            n_checks++;
            if (ml_b !== (b == 2)) begin n_fail++; $display("FAIL part_last b%0d got %b want %b", b, ml_b, b == 2); end
            step();
        end
        n_checks++;
        if (mv_b !== 1'b0) begin n_fail++; $display("FAIL part_idle got %b want 0", mv_b); end
    endtask

    task automatic test_back_to_back();
        logic [639:0] e;
        int base;
        int b;
        in_a = mk_frame(200);
        sv_a = 1;
        step();
        in_a = mk_frame(300);
        n_checks++;
        if (sr_a !== 1'b1) begin n_fail++; $display("FAIL b2b_s_ready got %b want 1", sr_a); end
        for (int i = 0; i < 4; i++) begin
            base = (i < 2) ? 200 : 300;
            b = i % 2;
            e = exp_beat(base, b, 20, 0);
            n_checks++;
            if (mv_a !== 1'b1) begin n_fail++; $display("FAIL b2b_valid i%0d got %b want 1", i, mv_a); end
            n_checks++;
            if (out_a !== e[319:0]) begin n_fail++; $display("FAIL b2b_out i%0d got %h want %h", i, out_a, e[319:0]); end
            n_checks++;
            if (beat_a !== 2'(b)) begin n_fail++; $display("FAIL b2b_beat i%0d got %0d want %0d", i, beat_a, b); end
            n_checks++;
            if (ml_a !== (b == 1)) begin n_fail++; $display("FAIL b2b_last i%0d got %b want %b", i, ml_a, b == 1); end
            step();
            if (i == 0) sv_a = 0;
        end
        n_checks++;
        if (mv_a !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %b want 0", mv_a); end
    endtask

    task automatic test_stall();
        logic [639:0] e;
        int base;
        int b;
        bit pending;
        bit acc;
        mr_a = 0;
        in_a = mk_frame(400);
        sv_a = 1;
        n_checks++;
        if (sr_a !== 1'b1) begin n_fail++; $display("FAIL stall_rdy0 got %b want 1", sr_a); end
        step();
        in_a = mk_frame(500);
        n_checks++;
        if (sr_a !== 1'b1) begin n_fail++; $display("FAIL stall_rdy1 got %b want 1", sr_a); end
        step();
        in_a = mk_frame(600);
        e = exp_beat(400, 0, 20, 0);
        for (int s = 0; s < 3; s++) begin
            n_checks++;
            if (sr_a !== 1'b0) begin n_fail++; $display("FAIL stall_full s%0d got %b want 0", s, sr_a); end
            n_checks++;
            if (mv_a !== 1'b1) begin n_fail++; $display("FAIL stall_valid s%0d got %b want 1", s, mv_a); end
            n_checks++;
            if (out_a !== e[319:0] || beat_a !== 2'd0 || ml_a !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold s%0d got %h/%0d/%b want %h/0/0", s, out_a, beat_a, ml_a, e[319:0]);
            end
            step();
        end
        mr_a = 1;
        pending = 1;
        for (int i = 0; i < 6; i++) begin
            base = 400 + 100 * (i / 2);
            b = i % 2;
            e = exp_beat(base, b, 20, 0);
            n_checks++;
            if (mv_a !== 1'b1) begin n_fail++; $display("FAIL drain_valid i%0d got %b want 1", i, mv_a); end
            n_checks++;
            if (out_a !== e[319:0]) begin n_fail++; $display("FAIL drain_out i%0d got %h want %h", i, out_a, e[319:0]); end
            n_checks++;
            if (beat_a !== 2'(b) || ml_a !== (b == 1)) begin
                n_fail++;
                $display("FAIL drain_beat i%0d got %0d/%b want %0d/%b", i, beat_a, ml_a, b, b == 1);
            end
            acc = pending && sr_a;
            step();
            if (acc) begin
                pending = 0;
                sv_a = 0;
            end
        end
        n_checks++;
        if (pending !== 1'b0) begin n_fail++; $display("FAIL drain_third_accept got pending=%b want 0", pending); end
        n_checks++;
        if (mv_a !== 1'b0) begin n_fail++; $display("FAIL drain_idle got %b want 0", mv_a); end
        sv_a = 0;
    endtask

    task automatic test_reset_mid();
        logic [639:0] e;
        mr_a = 1;
        in_a = mk_frame(700);
        sv_a = 1;
        step();
        sv_a = 0;
        step();
        n_checks++;
        if (beat_a !== 2'd1 || mv_a !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre got beat=%0d valid=%b want 1/1", beat_a, mv_a);
        end
        reset = 1;
        step();
        reset = 0;
        #1;
        n_checks++;
        if (mv_a !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", mv_a); end
        n_checks++;
        if (beat_a !== 2'd0) begin n_fail++; $display("FAIL mid_beat got %0d want 0", beat_a); end
        n_checks++;
        if (sr_a !== 1'b1) begin n_fail++; $display("FAIL mid_s_ready got %b want 1", sr_a); end
        step();
        n_checks++;
        if (mv_a !== 1'b0) begin n_fail++; $display("FAIL mid_discard got %b want 0", mv_a); end
        in_a = mk_frame(800);
        sv_a = 1;
        step();
        sv_a = 0;
        for (int b = 0; b < 2; b++) begin
            e = exp_beat(800, b, 20, 0);
            n_checks++;
            if (mv_a !== 1'b1 || beat_a !== 2'(b)) begin
                n_fail++;
                $display("FAIL mid_new b%0d got valid=%b beat=%0d want 1/%0d", b, mv_a, beat_a, b);
            end
            n_checks++;
            if (out_a !== e[319:0]) begin n_fail++; $display("FAIL mid_out b%0d got %h want %h", b, out_a, e[319:0]); end
            step();
        end
        n_checks++;
        if (mv_a !== 1'b0) begin n_fail++; $display("FAIL mid_idle got %b want 0", mv_a); end
    endtask

    task automatic test_full_width();
        logic [639:0] e;
        mr_c = 1;
        in_c = mk_frame(900);
        sv_c = 1;
        step();
        for (int i = 0; i < 3; i++) begin
            e = exp_beat(900 + 100 * i, 0, 40, 0);
            n_checks++;
            if (mv_c !== 1'b1 || ml_c !== 1'b1 || beat_c !== 1'b0) begin
                n_fail++;
                $display("FAIL fw_ctl i%0d got v=%b l=%b b=%0d want 1/1/0", i, mv_c, ml_c, beat_c);
            end
            n_checks++;
            if (out_c !== e) begin n_fail++; $display("FAIL fw_out i%0d got %h want %h", i, out_c, e); end
            n_checks++;
            if (keep_c !== {40{1'b1}}) begin n_fail++; $display("FAIL fw_keep i%0d got %h want all ones", i, keep_c); end
            n_checks++;
            if (sr_c !== 1'b1) begin n_fail++; $display("FAIL fw_s_ready i%0d got %b want 1", i, sr_c); end
            if (i < 2) in_c = mk_frame(1000 + 100 * i);
            else sv_c = 0;
            step();
        end
        n_checks++;
        if (mv_c !== 1'b0) begin n_fail++; $display("FAIL fw_idle got %b want 0", mv_c); end
    endtask

    initial begin
        test_reset();
        test_default();
        test_partial();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_full_width();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mel_frame_serializer.md
# mel_frame_serializer

Parametrised successor to the mel filter-bank output reshaper. It accepts one full frame of N_IN mel coefficients per input handshake and streams it out as ceil(N_IN/OUT_WIDTH) beats of OUT_WIDTH lanes. A partial last beat is padded and flagged with a per-lane keep mask. A two-slot frame buffer lets the next frame be accepted while the current one drains, so back-to-back frames stream without a bubble. The block sits between the mel filter bank and the feature/DCT stage.

## Interface
- DATA_W, 16: bits per coefficient.
- N_IN, 40: coefficients per input frame; ≥1.
- OUT_WIDTH, 20: lanes per output beat; 1..N_IN; need not divide N_IN.
- PAD_VALUE, 0: value driven on lanes beyond N_IN in the last beat.
- Derived: BEATS = ceil(N_IN/OUT_WIDTH); LAST_LANES = N_IN - (BEATS-1)*OUT_WIDTH.

One clock; reset is synchronous and active-high.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- in  in  [DATA_W] x N_IN  input frame; element 0 is the lowest mel band.
- s_valid  in  1  input frame valid.
- s_ready  out  1  a buffer slot is free.
- out  out  [DATA_W] x OUT_WIDTH  current beat; lane j carries in[b*OUT_WIDTH+j].
- m_keep  out  OUT_WIDTH  lane j holds a real coefficient.
- m_beat  out  clog2(BEATS+1)  index b of the current beat within its frame.
- m_valid  out  1  beat valid.
- m_ready  in  1  downstream accepts beat.
- m_last  out  1  current beat is beat BEATS-1.

## Operation
- Storage: 2 slots of N_IN x DATA_W, write pointer wr, read pointer rd, occupancy cnt (0..2), beat counter beat (0..BEATS-1).
- Accept (s_valid && s_ready): copy `in` into slot wr, toggle wr, cnt+1.
- Output: m_valid = (cnt != 0). Beat b of slot rd drives `out`, m_keep, m_beat = b, and m_last = (b == BEATS-1).
- Pop (m_valid && m_ready): if beat == BEATS-1, then beat←0, toggle rd, cnt−1. Otherwise beat+1.
- Simultaneous accept and final-beat pop: cnt stays unchanged, and both pointers toggle.
- s_ready = (cnt < 2) && !reset. It is derived only from registered state, with no combinational path from m_ready or s_valid.
- m_keep is all ones on every beat except the last, where it is LAST_LANES ones in the LSBs. Masked lanes drive PAD_VALUE.
- When m_valid = 0, `out` and m_keep are don't-care. m_beat and m_last still reflect `beat`.
- Slot contents are not reset.

## Timing
- Reset values: m_valid 0, m_last = (BEATS==1), m_beat 0, s_ready 0 during reset and 1 on the first cycle after.
- Latency: a frame accepted at edge k has beat 0 valid in cycle k+1 (one register stage).
- Throughput: with m_ready held high, one beat per cycle and a new frame every BEATS cycles, with no idle cycle between frames.
- Stall: while m_valid && !m_ready, out, m_keep, m_beat, and m_last hold stable. m_valid never drops without a pop.
- Full (cnt = 2): s_ready is low. A frame presented then is held by upstream, not dropped.
- BEATS = 1: every beat is last. Each pop frees a slot.
- Reset mid-frame discards both slots and returns beat to 0. The first beat after reset belongs to a frame accepted after reset.

## Structure
- Package mel_reshape_pkg: DATA_W default, a sample_t typedef, and a ceil_div function used to derive BEATS and LAST_LANES.
- One sub-module, mel_beat_mux (combinational): given a slot and a beat index, produces the OUT_WIDTH lanes, PAD_VALUE insertion, and m_keep.
- Pointers, counters, and handshake logic stay in the top level.

## Test plan
- Default (N_IN=40, OUT_WIDTH=20), in[i]=i, m_ready=1: beat0 lanes 0..19 and beat1 lanes 20..39. m_last only on beat1, and m_keep = 0xFFFFF on both.
- N_IN=40, OUT_WIDTH=16: 3 beats. Beat2 lanes 0..7 = 32..39, lanes 8..15 = PAD_VALUE, and m_keep = 0x00FF.
- Back-to-back frames A then B with s_valid and m_ready always 1: beats A0 A1 B0 B1 on consecutive cycles. s_ready never drops below the rate needed for this.
- m_ready=0 while 3 frames are offered: the first 2 are accepted and then s_ready=0. Raising m_ready drains all 3 frames in order with output held stable during the stall.
- Reset asserted mid-drain on beat 1: m_valid is 0 the next cycle, s_ready=1 after reset, and the following frame starts at m_beat=0.
- OUT_WIDTH = N_IN = 40: every beat has m_last=1, m_keep all ones, and one frame per cycle is sustained.
